// File: rtl/window_pkg.sv
// Shared defaults and state encoding for the sequential window accumulator.
package window_pkg;

    localparam int DEF_PIX_W  = 8;
    localparam int DEF_N_TAPS = 9;
    localparam int DEF_SUM_W  = 12;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/window_sum_seq_if.sv
// Window-in / result-out handshake bundle between the window generator and normaliser.
interface window_sum_seq_if
    import window_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int N_TAPS = DEF_N_TAPS,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic                    in_valid;
    logic                    in_ready;
    logic [N_TAPS*PIX_W-1:0] win_in;
    logic [N_TAPS-1:0]       mask_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [SUM_W-1:0]        sum_out;
    logic [CNT_W-1:0]        cnt_out;

    modport master (
        output in_valid, win_in, mask_in, out_ready,
        input  in_ready, out_valid, sum_out, cnt_out
    );

    modport slave (
        input  in_valid, win_in, mask_in, out_ready,
        output in_ready, out_valid, sum_out, cnt_out
    );

endinterface

// File: rtl/acc_adder.sv
// WIDTH-bit ripple-carry adder built from chained 1-bit full-adder cells, carry-in tied low.
module acc_adder #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH-1:0] carry;

    assign carry[0] = 1'b0;

    // The final carry-out is never needed, so the chain stops at the MSB cell.
    for (genvar i = 0; i < WIDTH; i++) begin : gFaCell
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
        if (i < WIDTH - 1) begin : gCarry
            assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

// File: rtl/window_sum_seq.sv
// Masked 3x3 window sum using one shared adder, one tap per clock; also counts included taps.
module window_sum_seq
    import window_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int N_TAPS = DEF_N_TAPS,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    window_sum_seq_if.slave  bus,
    output logic             busy
);

    localparam int IDX_W = $clog2(N_TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SUM_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_TAPS*PIX_W-1:0] win_q, win_d;
    logic [N_TAPS-1:0]       mask_q, mask_d;

    logic                    tapSel;
    logic [PIX_W-1:0]        tapPix;
    logic [SUM_W-1:0]        addB;
    logic [SUM_W-1:0]        addSum;

    // Masked-out taps feed zero into the adder rather than skipping a cycle.
    assign tapSel = mask_q[idx_q];
    assign tapPix = win_q[int'(idx_q)*PIX_W +: PIX_W];
    assign addB   = tapSel ? SUM_W'(tapPix) : '0;

    acc_adder #(.WIDTH(SUM_W)) u_accAdder (
        .a_i   (acc_q),
        .b_i   (addB),
        .sum_o (addSum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    win_d   = bus.win_in;
                    mask_d  = bus.mask_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = addSum;
                cnt_d = cnt_q + CNT_W'(tapSel);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum_out   = acc_q;
    assign bus.cnt_out   = cnt_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_window_sum_seq.sv
// Self-checking bench: directed corner cases plus random windows against a tap-sum reference model.
module tb_window_sum_seq;

    logic clk;
    logic rst_n;
    logic busy;

    int checkCount = 0;
    int errorCount = 0;

    window_sum_seq_if bus ();

    window_sum_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model: plain sum of included pixels and a popcount of the mask.
    function automatic int modelSum(input logic [71:0] w, input logic [8:0] m);
        int s = 0;
        for (int i = 0; i < 9; i++) if (m[i]) s += int'(w[i*8 +: 8]);
        return s;
    endfunction

    function automatic int modelCnt(input logic [8:0] m);
        int c = 0;
        for (int i = 0; i < 9; i++) if (m[i]) c++;
        return c;
    endfunction

    function automatic logic [71:0] packWin(input int p0, input int p4, input int other);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(other);
        w[7:0]   = 8'(p0);
        w[39:32] = 8'(p4);
        return w;
    endfunction

    // Presents a window, measures latency to out_valid, checks the result, then drains it.
    task automatic applyStimulus(input string tag, input logic [71:0] w, input logic [8:0] m,
                                 input int holdCycles);
        int lat;
        int expSum;
        int expCnt;
        expSum = modelSum(w, m);
        expCnt = modelCnt(m);
        @(negedge clk);
        bus.win_in    = w;
        bus.mask_in   = m;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        checkOutput({tag, " inReady"}, int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.win_in   = {$urandom(), $urandom(), $urandom()};
        bus.mask_in  = 9'($urandom());
        lat = 0;
        while (lat < 20) begin
            lat++;
            if (bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, " latency"}, lat, 10);
        checkOutput({tag, " sum"}, int'(bus.sum_out), expSum);
        checkOutput({tag, " cnt"}, int'(bus.cnt_out), expCnt);
        repeat (holdCycles) @(negedge clk);
        checkOutput({tag, " holdValid"}, int'(bus.out_valid), 1);
        checkOutput({tag, " holdSum"}, int'(bus.sum_out), expSum);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, " drained"}, int'(bus.out_valid), 0);
        checkOutput({tag, " keepSum"}, int'(bus.sum_out), expSum);
        bus.out_ready = 1'b0;
    endtask

    logic [71:0] winA;
    logic [71:0] winB;
    logic [71:0] seqWin [3];
    logic [8:0]  seqMask [3];
    int          acceptCycle [3];
    int          cycleNum = 0;

    always @(posedge clk) cycleNum++;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.win_in    = '0;
        bus.mask_in   = '0;
        rst_n         = 1'b0;
        #12;
        checkOutput("reset inReady", int'(bus.in_ready), 1);
        checkOutput("reset outValid", int'(bus.out_valid), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset sum", int'(bus.sum_out), 0);
        checkOutput("reset cnt", int'(bus.cnt_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency counted from the accept edge: 9 further edges, reported as lat==10 including the first sample.
        applyStimulus("allMax", {9{8'd255}}, 9'h1FF, 0);
        applyStimulus("twoTaps", packWin(10, 20, 200), 9'b000010001, 1);
        applyStimulus("maskZero", {$urandom(), $urandom(), $urandom()}, 9'h000, 0);

        // Backpressure: result must hold and a waiting window must not be taken.
        winA = packWin(1, 2, 3);
        winB = packWin(50, 60, 7);
        @(negedge clk);
        bus.win_in   = winA;
        bus.mask_in  = 9'h1FF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.win_in  = winB;
        bus.mask_in = 9'h0F0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("bp validAfter9", int'(bus.out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp inReady", int'(bus.in_ready), 0);
            checkOutput("bp sum", int'(bus.sum_out), modelSum(winA, 9'h1FF));
            checkOutput("bp cnt", int'(bus.cnt_out), 9);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp toIdle", int'(bus.in_ready), 1);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp newAccept", int'(busy), 1);
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("bp newValid", int'(bus.out_valid), 1);
        checkOutput("bp newSum", int'(bus.sum_out), modelSum(winB, 9'h0F0));
        checkOutput("bp newCnt", int'(bus.cnt_out), 4);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset in the middle of accumulation.
        @(negedge clk);
        bus.win_in   = {9{8'd100}};
        bus.mask_in  = 9'h1FF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset outValid", int'(bus.out_valid), 0);
        checkOutput("midReset busy", int'(busy), 0);
        checkOutput("midReset sum", int'(bus.sum_out), 0);
        checkOutput("midReset inReady", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("afterReset", {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 9'h1FF, 0);

        // Back-to-back: in_valid and out_ready held high over three windows.
        for (int j = 0; j < 3; j++) begin
            seqWin[j]  = {$urandom(), $urandom(), $urandom()};
            seqMask[j] = 9'($urandom());
        end
        begin
            int accepts = 0;
            int results = 0;
            int budget  = 0;
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.win_in    = seqWin[0];
            bus.mask_in   = seqMask[0];
            while (results < 3 && budget < 100) begin
                budget++;
                if (bus.out_valid) begin
                    checkOutput("b2b sum", int'(bus.sum_out), modelSum(seqWin[results], seqMask[results]));
                    checkOutput("b2b cnt", int'(bus.cnt_out), modelCnt(seqMask[results]));
                    results++;
                end
                if (bus.in_ready && bus.in_valid && accepts < 3) begin
                    acceptCycle[accepts] = cycleNum;
                    accepts++;
                    @(negedge clk);
                    if (accepts < 3) begin
                        bus.win_in  = seqWin[accepts];
                        bus.mask_in = seqMask[accepts];
                    end else begin
                        bus.in_valid = 1'b0;
                    end
                end else begin
                    @(negedge clk);
                end
            end
            checkOutput("b2b results", results, 3);
            checkOutput("b2b gap01", acceptCycle[1] - acceptCycle[0], 11);
            checkOutput("b2b gap12", acceptCycle[2] - acceptCycle[1], 11);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
        end

        // Random windows and masks with random result hold times.
        for (int r = 0; r < 15; r++) begin
            applyStimulus("random", {$urandom(), $urandom(), $urandom()}, 9'($urandom()),
                          int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
